// File: rtl/csa_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// csa_seq_ctrl_if
//
// Purpose: groups the request/response signals of the byte-serial
// multi-precision adder controller (csa_seq_ctrl).
//
// Signals (W = 8*NBYTES):
//   START  requester -> controller  request, sampled only when idle
//   A, B   requester -> controller  operands, captured on accepted START
//   C_IN   requester -> controller  carry into byte 0
//   SUB    requester -> controller  subtract request (only with CSA_SEQ_SUB_EN)
//   BUSY   controller -> requester  high whenever an operation is in flight
//   DONE   controller -> requester  one-cycle pulse, result valid
//   SUM    controller -> requester  registered W-bit result
//   C_OUT  controller -> requester  registered carry out of bit W-1
//
// Optional feature macro: CSA_SEQ_SUB_EN (adds the SUB signal).
// ---------------------------------------------------------------------------
interface csa_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         START;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_IN;
`ifdef CSA_SEQ_SUB_EN
    logic         SUB;
`endif
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] SUM;
    logic         C_OUT;

`ifdef CSA_SEQ_SUB_EN
    modport master (
        output START, A, B, C_IN, SUB,
        input  BUSY, DONE, SUM, C_OUT
    );

    modport slave (
        input  START, A, B, C_IN, SUB,
        output BUSY, DONE, SUM, C_OUT
    );
`else
    modport master (
        output START, A, B, C_IN,
        input  BUSY, DONE, SUM, C_OUT
    );

    modport slave (
        input  START, A, B, C_IN,
        output BUSY, DONE, SUM, C_OUT
    );
`endif
endinterface

// File: rtl/csa_seq_ctrl.sv
// ---------------------------------------------------------------------------
// csa_seq_ctrl
//
// Purpose: byte-serial multi-precision adder controller. A W = 8*NBYTES bit
// addition is computed by stepping a single 8-bit adder (csa_seq_ctrl_csa8)
// across the operand bytes, least significant first, one byte per cycle,
// with the carry chained through a register between bytes.
//
// Ports:
//   CLK   clock, all state updates on the rising edge
//   RST   synchronous active-high reset (dominates START)
//   bus   csa_seq_ctrl_if slave modport: START/A/B/C_IN[/SUB] in,
//         BUSY/DONE/SUM/C_OUT out
//
// Timing: START accepted at edge 0 -> byte k written at edge k+1 ->
// DONE high for the cycle after edge NBYTES -> idle again after edge
// NBYTES+1. SUM/C_OUT are registered and hold until the next accepted START.
//
// Optional feature macro: CSA_SEQ_SUB_EN. When defined, SUB=1 at START
// captures ~B and forces the initial carry to 1 so the result is A-B mod 2^W
// (C_OUT=1 means no borrow). When undefined the block is add-only.
// ---------------------------------------------------------------------------

// 8-bit ripple adder slice shared by every byte step.
module csa_seq_ctrl_csa8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] sum,
    output logic       c_out
);
    logic [8:0] carry;

    assign carry[0] = c_in;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = carry[8];
endmodule

module csa_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic            CLK,
    input  logic            RST,
    csa_seq_ctrl_if.slave   bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  opa_q, opa_d;
    logic [W-1:0]  opb_q, opb_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cy_q, cy_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Byte lanes of the captured operands, selected by idx for the adder.
    logic [7:0]    opa_bytes [NBYTES];
    logic [7:0]    opb_bytes [NBYTES];
    logic [7:0]    csa_a;
    logic [7:0]    csa_b;
    logic [7:0]    csa_sum;
    logic          csa_cout;

    // SUM with the current byte lane replaced by the adder output; every
    // other lane keeps its registered value.
    logic [W-1:0]  sum_run;

    // Operand B and carry-in as they would be captured on an accepted START.
    logic [W-1:0]  start_b;
    logic          start_cy;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign opa_bytes[gi] = opa_q[8*gi +: 8];
            assign opb_bytes[gi] = opb_q[8*gi +: 8];
            assign sum_run[8*gi +: 8] = (idx_q == IW'(gi)) ? csa_sum
                                                           : sum_q[8*gi +: 8];
        end
    endgenerate

    assign csa_a = opa_bytes[idx_q];
    assign csa_b = opb_bytes[idx_q];

    csa_seq_ctrl_csa8 u_csa (
        .a     (csa_a),
        .b     (csa_b),
        .c_in  (cy_q),
        .sum   (csa_sum),
        .c_out (csa_cout)
    );

`ifdef CSA_SEQ_SUB_EN
    // Two's complement subtraction: A + ~B + 1, so C_IN is ignored.
    assign start_b  = bus.SUB ? ~bus.B : bus.B;
    assign start_cy = bus.SUB ? 1'b1   : bus.C_IN;
`else
    assign start_b  = bus.B;
    assign start_cy = bus.C_IN;
`endif

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    opa_d   = bus.A;
                    opb_d   = start_b;
                    cy_d    = start_cy;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // START is not looked at here: requests while busy are dropped.
                sum_d = sum_run;
                cy_d  = csa_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = csa_cout;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            ST_DONE: begin
                // BUSY covers the DONE cycle and falls together with DONE.
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.SUM   = sum_q;
    assign bus.C_OUT = cout_q;
endmodule

// File: tb/tb_csa_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_seq_ctrl
//
// Bench for csa_seq_ctrl with NBYTES=4. Directed vectors from a table,
// hand-written multi-cycle sequences (reset, START while busy, reset
// mid-operation) and random operations checked against an arithmetic
// reference model. Also usable with CSA_SEQ_SUB_EN defined.
// ---------------------------------------------------------------------------
module tb_csa_seq_ctrl;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic CLK;
    logic RST;

    csa_seq_ctrl_if #(.NBYTES(NBYTES)) bus ();

    csa_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain W+1 bit arithmetic, MSB is the carry out of bit W-1.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        return r;
    endfunction

    task automatic drive(input logic start, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        bus.START = start;
        bus.A     = a;
        bus.B     = b;
        bus.C_IN  = cin;
`ifdef CSA_SEQ_SUB_EN
        bus.SUB   = sub;
`else
        if (sub) $display("note: sub request ignored in add-only build");
`endif
    endtask

    // One full operation from the idle state: accept, wait for DONE with a
    // cycle budget, check latency/result, then check the return to idle.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        int  lat;
        logic busy_ok;
        drive(1'b1, a, b, cin, sub);
        tick();
        check({tag, "_accept_busy"}, (W+1)'(bus.BUSY), (W+1)'(1));
        check({tag, "_start_clears_sum"}, {bus.C_OUT, bus.SUM}, '0);
        drive(1'b0, $urandom, $urandom, 1'b0, 1'b0);
        lat     = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= NBYTES + 3; i++) begin
            tick();
            if (bus.BUSY !== 1'b1) busy_ok = 1'b0;
            if (bus.DONE === 1'b1) begin
                lat = i;
                break;
            end
        end
        check({tag, "_done_latency"}, (W+1)'(lat), (W+1)'(NBYTES));
        check({tag, "_busy_held"}, (W+1)'(busy_ok), (W+1)'(1));
        check({tag, "_result"}, {bus.C_OUT, bus.SUM}, {exp_cout, exp_sum});
        $display("op %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d", tag, a, b, cin, sub,
                 bus.SUM, bus.C_OUT);
        tick();
        check({tag, "_idle_after"}, (W+1)'({bus.BUSY, bus.DONE}), '0);
        check({tag, "_result_hold"}, {bus.C_OUT, bus.SUM}, {exp_cout, exp_sum});
    endtask

    initial begin
        logic [W:0] exp;
        int   n_done;
        logic busy_ok;

        vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1});
        vecs.push_back('{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0});
`ifdef CSA_SEQ_SUB_EN
        vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0});
        vecs.push_back('{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1});
`endif

        // Reset held two cycles with START high: nothing may start.
        RST = 1'b1;
        drive(1'b1, 32'h12345678, 32'h11111111, 1'b1, 1'b0);
        tick();
        tick();
        check("reset_state", {bus.C_OUT, bus.SUM}, '0);
        check("reset_flags", (W+1)'({bus.BUSY, bus.DONE}), '0);
        RST = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        check("reset_no_start", (W+1)'({bus.BUSY, bus.DONE}), '0);

        // Directed table.
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].sum, vecs[i].cout);

        // START while busy: second request at edge 2 must be ignored.
        drive(1'b1, 32'h00000001, 32'h00000002, 1'b0, 1'b0);
        tick();                                   // edge 0
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();                                   // edge 1
        drive(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
        tick();                                   // edge 2
        drive(1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
        n_done  = 0;
        busy_ok = 1'b1;
        for (int i = 3; i <= 12; i++) begin
            tick();
            if (bus.DONE === 1'b1) begin
                n_done++;
                check("busy_start_result", {bus.C_OUT, bus.SUM}, {1'b0, 32'h00000003});
                check("busy_start_done_edge", (W+1)'(i), (W+1)'(NBYTES));
            end
            if (i < NBYTES && bus.BUSY !== 1'b1) busy_ok = 1'b0;
        end
        check("busy_start_single_done", (W+1)'(n_done), (W+1)'(1));
        check("busy_start_busy_held", (W+1)'(busy_ok), (W+1)'(1));
        $display("op busy_start sum=%h dones=%0d", bus.SUM, n_done);

        // Reset mid-operation discards the partial result.
        drive(1'b1, 32'h01010101, 32'h01010101, 1'b0, 1'b0);
        tick();                                   // edge 0
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();                                   // edge 1
        RST = 1'b1;
        tick();                                   // edge 2
        check("midreset_state", {bus.C_OUT, bus.SUM}, '0);
        check("midreset_flags", (W+1)'({bus.BUSY, bus.DONE}), '0);
        RST = 1'b0;
        n_done = 0;
        for (int i = 0; i < NBYTES + 2; i++) begin
            tick();
            if (bus.DONE === 1'b1 || bus.BUSY === 1'b1) n_done++;
        end
        check("midreset_no_done", (W+1)'(n_done), '0);
        run_op("after_midreset", 32'h01010101, 32'h01010101, 1'b0, 1'b0, 32'h02020202, 1'b0);

        // Random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra, rb;
            logic rc, rs;
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) ra = '1;
            rc = 1'($urandom_range(0, 1));
`ifdef CSA_SEQ_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            exp = model(ra, rb, rc, rs);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, exp[W-1:0], exp[W]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
